// File: rtl/rv32i_types_pkg.sv
// Shared RV32I type definitions: ALU operation codes and the M-extension muldiv op codes.
// Divider support in muldiv_unit is controlled by the MULDIV_DIV_EN macro.
package rv32i_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_ops;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    // Bit 2 separates divide/remainder from multiply; bit 0 marks unsigned divide variants.
    function automatic logic isDivOp(muldiv_op_t o);
        return o[2];
    endfunction

    function automatic logic isASigned(muldiv_op_t o);
        return (o == MUL) || (o == MULH) || (o == MULHSU) || (o == DIV) || (o == REM);
    endfunction

    function automatic logic isBSigned(muldiv_op_t o);
        return (o == MUL) || (o == MULH) || (o == DIV) || (o == REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negation, used both to take operand
// magnitudes on entry and to restore result signs after the iterative core.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? ({WIDTH{1'b0}} - i_value) : i_value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply and restoring divide on magnitudes.
// Define MULDIV_DIV_EN to build the divider; without it divide ops bypass and return zero.
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    muldiv_op_t         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_negLo;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic               w_bypass;
    logic [2*WIDTH-1:0] w_entryAcc;
    logic               w_entryNegLo;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [2*WIDTH-1:0] w_fixAcc;
    logic [WIDTH-1:0]   w_fixResult;

`ifdef MULDIV_DIV_EN
    logic               r_negHi;
    logic               w_entryNegHi;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divTrial;
    logic [2*WIDTH-1:0] w_divNext;
    logic [WIDTH-1:0]   w_fixLo;
    logic [WIDTH-1:0]   w_fixHi;
`endif

    // DONE behaves like IDLE for acceptance so a held start streams back-to-back.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_aNeg   = isASigned(op) && a[WIDTH-1];
    assign w_bNeg   = isBSigned(op) && b[WIDTH-1];

    muldiv_signfix #(.WIDTH(WIDTH)) u_magA (
        .i_value  (a),
        .i_negate (w_aNeg),
        .o_value  (w_aMag)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_magB (
        .i_value  (b),
        .i_negate (w_bNeg),
        .o_value  (w_bMag)
    );

    // Divide special cases preload the final answer and skip CALC with sign fix-up disabled.
    always_comb begin
        w_bypass     = 1'b0;
        w_entryAcc   = {{WIDTH{1'b0}}, w_aMag};
        w_entryNegLo = w_aNeg ^ w_bNeg;
`ifdef MULDIV_DIV_EN
        w_entryNegHi = w_aNeg;
        if (isDivOp(op)) begin
            if (b == {WIDTH{1'b0}}) begin
                w_bypass     = 1'b1;
                w_entryAcc   = {a, {WIDTH{1'b1}}};
                w_entryNegLo = 1'b0;
                w_entryNegHi = 1'b0;
            end else if (!op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}})) begin
                w_bypass     = 1'b1;
                w_entryAcc   = {{WIDTH{1'b0}}, a};
                w_entryNegLo = 1'b0;
                w_entryNegHi = 1'b0;
            end
        end
`else
        if (isDivOp(op)) begin
            w_bypass     = 1'b1;
            w_entryAcc   = {2*WIDTH{1'b0}};
            w_entryNegLo = 1'b0;
        end
`endif
    end

    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    // Remainder lives in the high half, quotient bits shift into the low half.
    assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_divTrial = w_divShift - {1'b0, r_opnd};
    assign w_divNext  = w_divTrial[WIDTH] ? {w_divShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                          : {w_divTrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    muldiv_signfix #(.WIDTH(WIDTH)) u_fixLo (
        .i_value  (r_acc[WIDTH-1:0]),
        .i_negate (r_negLo),
        .o_value  (w_fixLo)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fixHi (
        .i_value  (r_acc[2*WIDTH-1:WIDTH]),
        .i_negate (r_negHi),
        .o_value  (w_fixHi)
    );
`endif

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fixAcc (
        .i_value  (r_acc),
        .i_negate (r_negLo),
        .o_value  (w_fixAcc)
    );

    always_comb begin
        w_fixResult = w_fixAcc[2*WIDTH-1:WIDTH];
        if (!isDivOp(r_op)) begin
            if (r_op == MUL) begin
                w_fixResult = w_fixAcc[WIDTH-1:0];
            end
        end else begin
`ifdef MULDIV_DIV_EN
            w_fixResult = r_op[1] ? w_fixHi : w_fixLo;
`else
            w_fixResult = {WIDTH{1'b0}};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_negLo  <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_negHi  <= 1'b0;
`endif
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_acc   <= w_entryAcc;
                        r_opnd  <= w_bMag;
                        r_negLo <= w_entryNegLo;
`ifdef MULDIV_DIV_EN
                        r_negHi <= w_entryNegHi;
`endif
                        r_state <= w_bypass ? S_FIX : S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
`ifdef MULDIV_DIV_EN
                    r_acc <= isDivOp(r_op) ? w_divNext : w_mulNext;
`else
                    r_acc <= w_mulNext;
`endif
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fixResult;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed, randomized, streaming and reset cases
// against a 64-bit arithmetic reference model; follows MULDIV_DIV_EN like the design.
`timescale 1ns/1ps
module tb_muldiv_unit;
    import rv32i_types::*;

    logic        clk;
    logic        rst;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] lastResult = 32'h0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic on 64-bit integers, RISC-V M semantics including divide corner cases.
    function automatic logic [31:0] refModel(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      ux;
        longint      uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
`ifndef MULDIV_DIV_EN
        if (o[2]) return 32'h0;
`endif
        case (o)
            MUL:    begin p = 64'(sx * sy); return p[31:0];  end
            MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
            DIV: begin
                if (y == 32'h0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                p = 64'(sx / sy); return p[31:0];
            end
            REM: begin
                if (y == 32'h0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                p = 64'(sx % sy); return p[31:0];
            end
            DIVU: begin
                if (y == 32'h0) return 32'hFFFFFFFF;
                return x / y;
            end
            default: begin
                if (y == 32'h0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int expLatency(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return 34;
`ifdef MULDIV_DIV_EN
        if (y == 32'h0) return 2;
        if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 2;
        return 34;
`else
        return 2;
`endif
    endfunction

    function automatic logic [31:0] divExp(input logic [31:0] v);
`ifdef MULDIV_DIV_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // One operation: present start for a single edge, scramble inputs while busy, then check.
    task automatic applyStimulus(input muldiv_op_t opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                 input logic [31:0] expIn, input bit releaseReset, input string tag);
        int cycles;
        int busyCycles;
        int lat;
        bit sawDone;
        bit heldOk;
        lat = expLatency(opIn, aIn, bIn);
        @(negedge clk);
        if (releaseReset) rst = 1'b0;
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        cycles     = 0;
        busyCycles = 0;
        sawDone    = 1'b0;
        heldOk     = 1'b1;
        while (!sawDone && cycles < 200) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            op    = muldiv_op_t'(3'($urandom_range(0, 7)));
            a     = $urandom;
            b     = $urandom;
            if (busy) busyCycles++;
            if (done) sawDone = 1'b1;
            else if (result !== lastResult) heldOk = 1'b0;
        end
        checkOutput({tag, "/done"}, 64'(sawDone), 64'(1));
        checkOutput({tag, "/latency"}, 64'(cycles), 64'(lat));
        checkOutput({tag, "/busyCycles"}, 64'(busyCycles), 64'(lat - 1));
        checkOutput({tag, "/heldResult"}, 64'(heldOk), 64'(1));
        checkOutput({tag, "/result"}, 64'(result), 64'(expIn));
        lastResult = expIn;
    endtask

    initial begin
        logic [31:0] sa [3];
        logic [31:0] sb [3];
        int          cycles;
        bit          got;

        rst   = 1'b1;
        start = 1'b0;
        op    = MUL;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset/busy", 64'(busy), 64'(0));
        checkOutput("reset/done", 64'(done), 64'(0));
        checkOutput("reset/result", 64'(result), 64'(0));

        applyStimulus(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, "mul7");
        applyStimulus(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulhMin");
        applyStimulus(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhuMax");
        applyStimulus(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, "mulhsu");
        applyStimulus(DIV,    32'hFFFFFFF9, 32'd2,        divExp(32'hFFFFFFFD), 1'b0, "divNeg");
        applyStimulus(REM,    32'hFFFFFFF9, 32'd2,        divExp(32'hFFFFFFFF), 1'b0, "remNeg");
        applyStimulus(DIVU,   32'd100,      32'd7,        divExp(32'd14), 1'b0, "divu");
        applyStimulus(REMU,   32'd100,      32'd7,        divExp(32'd2), 1'b0, "remu");
        applyStimulus(DIVU,   32'h1234,     32'h0,        divExp(32'hFFFFFFFF), 1'b0, "divuZero");
        applyStimulus(REM,    32'h1234,     32'h0,        divExp(32'h1234), 1'b0, "remZero");
        applyStimulus(DIV,    32'h80000000, 32'hFFFFFFFF, divExp(32'h80000000), 1'b0, "divOvf");
        applyStimulus(REM,    32'h80000000, 32'hFFFFFFFF, divExp(32'h0), 1'b0, "remOvf");
        applyStimulus(DIV,    32'd10,       32'd2,        divExp(32'd5), 1'b0, "div10by2");

        for (int i = 0; i < 30; i++) begin
            muldiv_op_t  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = muldiv_op_t'(3'($urandom_range(0, 7)));
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus(ro, ra, rb, refModel(ro, ra, rb), 1'b0, $sformatf("rand%0d", i));
        end

        // Held start: each DONE cycle accepts the next operands directly.
        for (int k = 0; k < 3; k++) begin
            sa[k] = $urandom;
            sb[k] = $urandom;
        end
        @(negedge clk);
        start = 1'b1;
        op    = MUL;
        a     = sa[0];
        b     = sb[0];
        for (int k = 0; k < 3; k++) begin
            cycles = 0;
            got    = 1'b0;
            while (!got && cycles < 200) begin
                @(negedge clk);
                cycles++;
                if (done) got = 1'b1;
                else begin
                    a = $urandom;
                    b = $urandom;
                end
            end
            checkOutput($sformatf("stream%0d/interval", k), 64'(cycles), 64'(34));
            checkOutput($sformatf("stream%0d/result", k), 64'(result), 64'(refModel(MUL, sa[k], sb[k])));
            if (k < 2) begin
                a = sa[k+1];
                b = sb[k+1];
            end else begin
                start = 1'b0;
            end
        end
        lastResult = refModel(MUL, sa[2], sb[2]);

        applyStimulus(MUL, 32'd3, 32'd5, 32'd15, 1'b0, "preReset");

        // Reset in the middle of a multiply must clear everything at once.
        @(negedge clk);
        start = 1'b1;
        op    = MUL;
        a     = 32'd9;
        b     = 32'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midReset/busy", 64'(busy), 64'(0));
        checkOutput("midReset/done", 64'(done), 64'(0));
        checkOutput("midReset/result", 64'(result), 64'(0));
        lastResult = 32'h0;
        applyStimulus(MUL, 32'h12345678, 32'd3, 32'h369D0368, 1'b1, "postReset");
        applyStimulus(MULHU, 32'hDEADBEEF, 32'h12345678, refModel(MULHU, 32'hDEADBEEF, 32'h12345678), 1'b0, "postResetHu");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64, even).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The module SHALL have port op, input, 3 bits, type muldiv_op_t: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
REQ-006 The module SHALL have ports a and b, inputs, WIDTH bits each: operands (a = dividend or multiplicand), captured when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-008 The module SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-009 The module SHALL have port result, output, WIDTH bits: the last completed result, held until the next done.

Function
REQ-010 The state machine SHALL have states IDLE, CALC, FIX and DONE: IDLE->CALC on accepted start; CALC->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-011 start with busy high SHALL be ignored; op, a and b SHALL be registered on acceptance, with no dependence on later input changes.
REQ-012 busy SHALL be high from the cycle after acceptance through FIX, and low in DONE and IDLE.
REQ-013 done SHALL be high in DONE only, exactly WIDTH+2 cycles after the accepting edge; result SHALL update on the same edge that asserts done.
REQ-014 A new start SHALL be acceptable in the cycle done is high (DONE->IDLE does not block: DONE SHALL accept start and go directly to CALC).
REQ-015 Multiply SHALL be iterative shift-add on operand magnitudes, one bit per cycle, into a 2*WIDTH accumulator.
REQ-016 The FIX state SHALL negate the accumulator when the operand signs differ. Signedness: MUL and MULH, both signed; MULHSU, a signed and b unsigned; MULHU, both unsigned.
REQ-017 MUL SHALL return the low WIDTH bits; MULH, MULHSU and MULHU SHALL return the high WIDTH bits.
REQ-018 Divide SHALL be restoring, one quotient bit per cycle, on magnitudes; the quotient sign SHALL be a^b and the remainder sign SHALL be the sign of a (DIV/REM signed; DIVU/REMU unsigned).
REQ-019 Divide by zero SHALL bypass CALC (IDLE->FIX->DONE, done 2 cycles after acceptance) and return quotient all-ones and remainder a.
REQ-020 Signed overflow (a = most negative, b = all-ones, DIV/REM) SHALL bypass CALC and return quotient a and remainder 0, with the same 2-cycle latency.

Reset
REQ-021 rst SHALL force IDLE immediately: busy=0, done=0, result=0, all internal registers cleared, including mid-operation; no partial result SHALL ever appear.
REQ-022 The first rising clk edge after rst deasserts SHALL be able to accept start.

Configuration
REQ-023 With macro MULDIV_DIV_EN defined, all eight ops SHALL be implemented as above.
REQ-024 With MULDIV_DIV_EN undefined, the divider logic SHALL be absent; ops DIV, DIVU, REM and REMU SHALL take the 2-cycle bypass path and return result 0; multiply behaviour SHALL be unchanged.

Structure
REQ-025 The muldiv_op_t enum SHALL be declared in the shared rv32i_types package, next to alu_ops.
REQ-026 One sub-module, muldiv_signfix, SHALL provide the combinational magnitude and conditional two's-complement negation; it SHALL be parametrised by width and used for operand entry and result fix-up.
REQ-027 The iteration count SHALL be a $clog2(WIDTH+1)-bit counter; no other parameters SHALL be needed.

Verification (WIDTH=32)
REQ-028 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, with done exactly 34 cycles after the accepting edge and busy high for 33 cycles.
REQ-029 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-031 DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM the same operands -> 0; each with done 2 cycles after acceptance.
REQ-032 Check stream, reset and macro-off behaviour:
- start held high continuously -> back-to-back results, each 34 cycles apart, with a and b changes while busy having no effect.
- rst pulsed in cycle 10 of a MUL -> busy, done and result all 0 immediately, and the next op correct.
- MULDIV_DIV_EN undefined -> DIV 10/2 returns 0 after 2 cycles.
